// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared opcodes, FSM states and sizing helper for the multiply/divide unit
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIN
    } state_t;

    // Counter must hold the value n itself, not just n-1.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one combinational restoring-division step
module mdu_divstep #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem_in,
    input  logic [N-1:0] divisor,
    input  logic         bit_in,
    output logic [N-1:0] rem_out,
    output logic         q_bit
);

    logic [N:0]   shifted;
    logic [N-1:0] diff;

    // rem_in < divisor holds on entry, so whichever branch is kept fits in N bits.
    assign shifted = {rem_in, bit_in};
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign diff    = shifted[N-1:0] - divisor;
    assign rem_out = q_bit ? diff : shifted[N-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit owning the HI/LO registers
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         divzero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = cnt_width(N);

    state_t          state, next_state;
    logic [CW-1:0]   count;
    logic [2*N-1:0]  acc;
    logic [N-1:0]    opnd;
    logic            neg_res, neg_rem, is_div, divz;

    logic            signed_op;
    logic [N-1:0]    a_mag, b_mag;
    logic [N:0]      mul_sum;
    logic [2*N-1:0]  mul_next, div_next;
    logic [N-1:0]    rem_out;
    logic            q_bit;
    logic [2*N-1:0]  prod_fix;
    logic [N-1:0]    rem_fix, quo_fix;

    assign busy      = (state != IDLE);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_mag     = (signed_op && a[N-1]) ? (~a + 1'b1) : a;
    assign b_mag     = (signed_op && b[N-1]) ? (~b + 1'b1) : b;

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? opnd : '0)};
    assign mul_next = {mul_sum, acc[N-1:1]};

    // Divide: acc holds {remainder, dividend bits shifting out / quotient bits shifting in}.
    mdu_divstep #(.N(N)) u_divstep (
        .rem_in  (acc[2*N-1:N]),
        .divisor (opnd),
        .bit_in  (acc[N-1]),
        .rem_out (rem_out),
        .q_bit   (q_bit)
    );
    assign div_next = {rem_out, acc[N-2:0], q_bit};

    assign prod_fix = neg_res ? (~acc + 1'b1) : acc;
    assign rem_fix  = neg_rem ? (~acc[2*N-1:N] + 1'b1) : acc[2*N-1:N];
    assign quo_fix  = neg_res ? (~acc[N-1:0] + 1'b1) : acc[N-1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: next_state = MUL;
                        OP_DIV, OP_DIVU:   next_state = (b == '0) ? FIN : DIV;
                        default:           next_state = IDLE;
                    endcase
                end
            end
            MUL:     if (count == CW'(1)) next_state = FIN;
            DIV:     if (count == CW'(1)) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            acc     <= '0;
            opnd    <= '0;
            count   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            is_div  <= 1'b0;
            divz    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            done    <= 1'b0;
            divzero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                acc     <= {{N{1'b0}}, b_mag};
                                opnd    <= a_mag;
                                neg_res <= signed_op && (a[N-1] ^ b[N-1]);
                                neg_rem <= 1'b0;
                                is_div  <= 1'b0;
                                divz    <= 1'b0;
                                count   <= CW'(N);
                            end
                            OP_DIV, OP_DIVU: begin
                                acc     <= {{N{1'b0}}, a_mag};
                                opnd    <= b_mag;
                                neg_res <= signed_op && (a[N-1] ^ b[N-1]);
                                neg_rem <= signed_op && a[N-1];
                                is_div  <= 1'b1;
                                divz    <= (b == '0);
                                count   <= CW'(N);
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc   <= mul_next;
                    count <= count - 1'b1;
                end
                DIV: begin
                    acc   <= div_next;
                    count <= count - 1'b1;
                end
                FIN: begin
                    done    <= 1'b1;
                    divzero <= divz;
                    count   <= '0;
                    if (!divz) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   op;
    logic [N-1:0] a, b;
    logic         busy, done, divzero;
    logic [N-1:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          dones = 0;
    int          pushes = 0;
    logic [31:0] mhi = '0, mlo = '0;

    mul_div_unit #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .divzero (divzero),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && done) begin
            dones++;
            if (sb.size() == 0) begin
                check("spurious_done", done, 1'b0);
            end else begin
                e = sb.pop_front();
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("divzero", divzero, e.dz);
            end
        end
    end

    task automatic add_expect(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t  e;
        logic [63:0] p;
        longint sa, sbv, q, r;
        e.dz = 1'b0;
        e.hi = mhi;
        e.lo = mlo;
        case (o)
            OP_MULT: begin
                sa = $signed(x); sbv = $signed(y);
                p = sa * sbv;
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            OP_DIV: begin
                if (y == 0) e.dz = 1'b1;
                else begin
                    sa = $signed(x); sbv = $signed(y);
                    q = sa / sbv; r = sa % sbv;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end
            end
            default: begin
                if (y == 0) e.dz = 1'b1;
                else begin
                    e.lo = x / y; e.hi = x % y;
                end
            end
        endcase
        mhi = e.hi;
        mlo = e.lo;
        sb.push_back(e);
        pushes++;
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int lat, bc, exp_lat, exp_busy;
        add_expect(o, x, y);
        drive(o, x, y);
        lat = 0; bc = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                lat = k;
                break;
            end
        end
        exp_lat  = (o[1] && y == 0) ? 2 : N + 2;
        exp_busy = (o[1] && y == 0) ? 1 : N + 1;
        check("latency", lat, exp_lat);
        check("busy_cycles", bc, exp_busy);
    endtask

    task automatic do_mt(input logic [2:0] o, input logic [31:0] x);
        @(negedge clk);
        start = 1'b1; op = o; a = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (o == OP_MTHI) begin
            mhi = x;
            check("mthi", hi, x);
        end else begin
            mlo = x;
            check("mtlo", lo, x);
        end
        check("mt_busy", busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", {done, divzero}, 0);
        @(negedge clk);
        reset = 1'b0;

        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        do_op(OP_DIVU, 32'd100, 32'd0);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

        do_mt(OP_MTHI, 32'h1234_5678);
        do_mt(OP_MTLO, 32'h9ABC_DEF0);
        repeat (3) @(negedge clk);
        check("mt_keep_hi", hi, 32'h1234_5678);
        check("mt_keep_lo", lo, 32'h9ABC_DEF0);

        // Second start while busy must be dropped.
        add_expect(OP_MULT, 32'd12345, 32'hFFFF_FF00);
        drive(OP_MULT, 32'd12345, 32'hFFFF_FF00);
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd17; b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 100 && dones < pushes; k++) @(negedge clk);
        check("ignored_start_done", dones, pushes);
        repeat (40) @(negedge clk);

        // Reset mid-multiply aborts with no done.
        add_expect(OP_MULT, 32'hDEAD_BEEF, 32'h0000_1234);
        drive(OP_MULT, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        pushes--;
        mhi = '0; mlo = '0;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_busy", busy, 0);
        repeat (40) @(negedge clk);
        do_op(OP_DIVU, 32'd17, 32'd5);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = (i == 5) ? 32'd0 : ((i % 2) ? $urandom : 32'($urandom_range(1, 300)));
            do_op(3'(i % 4), x, y);
        end

        repeat (5) @(negedge clk);
        check("done_count", dones, pushes);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
